// File: rtl/video_rd_burst_gen_pkg.sv
// rtl/video_rd_burst_gen_pkg.sv - shared AXI constants, FSM states and clog2 helper
package video_rd_burst_gen_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_ADDR,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_rd_burst_gen_inflight_cnt.sv
// rtl/video_rd_burst_gen_inflight_cnt.sv - outstanding AR and in-flight beat counters
module video_rd_burst_gen_inflight_cnt
  import video_rd_burst_gen_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ar_fire,
  input  logic [15:0] ar_beats,
  input  logic        r_fire,
  input  logic        r_last,
  output logic [3:0]  out_tx,
  output logic [15:0] inflight_beats
);

  logic tx_dec;
  assign tx_dec = r_fire & r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tx         <= '0;
      inflight_beats <= '0;
    end else begin
      case ({ar_fire, tx_dec})
        2'b10:   out_tx <= out_tx + 4'd1;
        2'b01:   out_tx <= out_tx - 4'd1;
        default: out_tx <= out_tx;
      endcase
      // Increment and decrement land in the same cycle as a net change.
      inflight_beats <= inflight_beats + (ar_fire ? ar_beats : 16'd0) - (r_fire ? 16'd1 : 16'd0);
    end
  end

  a_tx_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ar_fire && !tx_dec && out_tx == 4'(MAX_OUTSTANDING)));
  a_tx_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(tx_dec && !ar_fire && out_tx == 4'd0));
  a_beats_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ar_fire && ({1'b0, inflight_beats} + {1'b0, ar_beats}) > 17'h0FFFF));
  a_beats_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_fire && !ar_fire && inflight_beats == 16'd0));

endmodule

// File: rtl/video_rd_burst_gen.sv
// rtl/video_rd_burst_gen.sv - VDMA read-address engine: frame/line walk, AR burst split, credit limit
module video_rd_burst_gen
  import video_rd_burst_gen_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FRAME_BUF_NUM   = 3,
  parameter int ARID            = 0,
  localparam int IW = clog2(FRAME_BUF_NUM)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic                      i_frame_start,
  input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] i_frame_size,
  input  logic [AXI_ADDR_WIDTH-1:0] i_line_stride,
  input  logic [15:0]               i_line_bytes,
  input  logic [15:0]               i_line_num,
  input  logic                      i_frame_mode,
  input  logic [IW-1:0]             i_wr_buf_idx,
  input  logic [15:0]               i_buf_free_beats,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [3:0]                m_axi_arid,
  input  logic                      m_axi_rvalid,
  input  logic                      m_axi_rready,
  input  logic                      m_axi_rlast,
  input  logic [1:0]                m_axi_rresp,
  output logic [IW-1:0]             o_rd_buf_idx,
  output logic                      o_busy,
  output logic                      o_line_done,
  output logic                      o_frame_done,
  output logic                      o_start_err,
  output logic                      o_rresp_err
);

  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int BSH = clog2(BPB);

  state_t        state;
  logic          aborted;
  logic          mode_r;
  logic [AW-1:0] frame_base;
  logic [AW-1:0] stride_r;
  logic [AW-1:0] addr;
  logic [15:0]   line_num_r;
  logic [15:0]   bpl_r;
  logic [15:0]   line_cnt;
  logic [15:0]   beats_left;
  logic [15:0]   burst_beats;

  logic [3:0]    out_tx;
  logic [15:0]   inflight_beats;
  logic          ar_fire;
  logic          r_fire;

  logic [IW-1:0] rd_idx_next;
  logic [15:0]   line_idx;
  logic          line_last;
  logic [12:0]   room_bytes;
  logic [15:0]   room_beats;
  logic [15:0]   b_calc;
  logic          credit_ok;

  assign ar_fire = m_axi_arvalid & m_axi_arready;
  assign r_fire  = m_axi_rvalid & m_axi_rready;

  assign m_axi_arsize  = 3'(BSH);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = 4'(ARID);
  assign o_busy        = (state != ST_IDLE);

  always_comb begin
    rd_idx_next = (i_wr_buf_idx == '0) ? IW'(FRAME_BUF_NUM - 1) : i_wr_buf_idx - 1'b1;
    line_idx    = mode_r ? (line_num_r - 16'd1 - line_cnt) : line_cnt;
    line_last   = (line_cnt == line_num_r - 16'd1);
    // Bytes left before the next 4 KB page; a burst must not cross it.
    room_bytes  = 13'h1000 - {1'b0, addr[11:0]};
    room_beats  = 16'(room_bytes >> BSH);
    b_calc      = 16'(MAX_BURST_LEN);
    if (beats_left < b_calc) b_calc = beats_left;
    if (room_beats < b_calc) b_calc = room_beats;
    credit_ok   = ({1'b0, i_buf_free_beats} >= ({1'b0, inflight_beats} + {1'b0, b_calc}));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      aborted       <= 1'b0;
      mode_r        <= 1'b0;
      frame_base    <= '0;
      stride_r      <= '0;
      addr          <= '0;
      line_num_r    <= '0;
      bpl_r         <= '0;
      line_cnt      <= '0;
      beats_left    <= '0;
      burst_beats   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      o_rd_buf_idx  <= '0;
      o_line_done   <= 1'b0;
      o_frame_done  <= 1'b0;
      o_start_err   <= 1'b0;
      o_rresp_err   <= 1'b0;
    end else begin
      o_line_done  <= 1'b0;
      o_frame_done <= 1'b0;
      if (r_fire && m_axi_rresp != AXI_RESP_OKAY) o_rresp_err <= 1'b1;
      if (i_frame_start && state != ST_IDLE) o_start_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_frame_start && i_enable) begin
            mode_r       <= i_frame_mode;
            stride_r     <= i_line_stride;
            line_num_r   <= i_line_num;
            bpl_r        <= i_line_bytes >> BSH;
            o_rd_buf_idx <= rd_idx_next;
            frame_base   <= i_base_addr + AW'(rd_idx_next) * i_frame_size;
            line_cnt     <= '0;
            aborted      <= 1'b0;
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!i_enable) begin
            aborted <= 1'b1;
            state   <= ST_DRAIN;
          end else if (line_num_r == 16'd0 || bpl_r == 16'd0) begin
            o_frame_done <= 1'b1;
            state        <= ST_DONE;
          end else begin
            addr       <= frame_base + AW'(line_idx) * stride_r;
            beats_left <= bpl_r;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_enable) begin
            aborted <= 1'b1;
            state   <= ST_DRAIN;
          end else if (out_tx < 4'(MAX_OUTSTANDING) && credit_ok) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(b_calc - 16'd1);
            burst_beats   <= b_calc;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            addr          <= addr + (AW'(burst_beats) << BSH);
            beats_left    <= beats_left - burst_beats;
            if (beats_left == burst_beats) begin
              o_line_done <= 1'b1;
              if (line_last) begin
                state <= ST_DRAIN;
              end else begin
                line_cnt <= line_cnt + 16'd1;
                state    <= ST_SETUP;
              end
            end else begin
              state <= ST_WAIT;
            end
            // An abort only takes effect once the pending AR has been accepted.
            if (!i_enable) begin
              aborted <= 1'b1;
              state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_tx == 4'd0) begin
            if (aborted) begin
              state <= ST_IDLE;
            end else begin
              o_frame_done <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  video_rd_burst_gen_inflight_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_inflight_cnt (
    .clk            (i_clk),
    .rst_n          (i_reset_n),
    .ar_fire        (ar_fire),
    .ar_beats       (burst_beats),
    .r_fire         (r_fire),
    .r_last         (m_axi_rlast),
    .out_tx         (out_tx),
    .inflight_beats (inflight_beats)
  );

endmodule

// File: tb/tb_video_rd_burst_gen.sv
// tb/tb_video_rd_burst_gen.sv - self-checking bench with AXI read slave and burst-list reference model
module tb_video_rd_burst_gen;

  typedef struct {
    logic        mode;
    int          line_num;
    int          line_bytes;
    logic [31:0] base;
    logic [31:0] stride;
    logic [31:0] fsize;
    int          wr;
    int          free;
    int          exp_n;
    logic [31:0] exp_first;
    int          exp_flen;
    logic [31:0] exp_last;
    int          exp_llen;
    int          exp_rd;
    int          exp_lines;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        frame_start;
  logic [31:0] base_addr;
  logic [31:0] frame_size;
  logic [31:0] line_stride;
  logic [15:0] line_bytes;
  logic [15:0] line_num;
  logic        frame_mode;
  logic [1:0]  wr_buf_idx;
  logic [15:0] buf_free;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [1:0]  rresp;
  logic [1:0]  rd_buf_idx;
  logic        busy;
  logic        line_done;
  logic        frame_done;
  logic        start_err;
  logic        rresp_err;

  int   checks = 0;
  int   failures = 0;
  ar_t  obs[$];
  ar_t  exp_q[$];
  int   rq[$];
  int   inflight_m;
  int   fd_cnt;
  int   ld_cnt;
  bit   r_hold;
  bit   r_err;
  bit   r_fired;
  bit   prev_wait;
  logic [39:0] prev_ar;

  always #5 clk = ~clk;

  video_rd_burst_gen dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_enable         (enable),
    .i_frame_start    (frame_start),
    .i_base_addr      (base_addr),
    .i_frame_size     (frame_size),
    .i_line_stride    (line_stride),
    .i_line_bytes     (line_bytes),
    .i_line_num       (line_num),
    .i_frame_mode     (frame_mode),
    .i_wr_buf_idx     (wr_buf_idx),
    .i_buf_free_beats (buf_free),
    .m_axi_arvalid    (arvalid),
    .m_axi_arready    (arready),
    .m_axi_araddr     (araddr),
    .m_axi_arlen      (arlen),
    .m_axi_arsize     (arsize),
    .m_axi_arburst    (arburst),
    .m_axi_arid       (arid),
    .m_axi_rvalid     (rvalid),
    .m_axi_rready     (rready),
    .m_axi_rlast      (rlast),
    .m_axi_rresp      (rresp),
    .o_rd_buf_idx     (rd_buf_idx),
    .o_busy           (busy),
    .o_line_done      (line_done),
    .o_frame_done     (frame_done),
    .o_start_err      (start_err),
    .o_rresp_err      (rresp_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // AXI read slave and output monitor; all decisions made on the falling edge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; rready = 1'b0;
    r_fired = 1'b0; prev_wait = 1'b0; inflight_m = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
        inflight_m = 0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rready = 1'b0; rresp = 2'd0;
        r_fired = 1'b0; prev_wait = 1'b0;
      end else begin
        if (frame_done) begin
          fd_cnt++;
          chk("done_after_data", 64'(rq.size()), 64'd0);
        end
        if (line_done) ld_cnt++;
        if (prev_wait) chk("ar_stable", {23'd0, arvalid, araddr, arlen}, {23'd0, 1'b1, prev_ar});

        if (r_fired) rvalid = 1'b0;
        if (!rvalid && rq.size() > 0 && !r_hold && $urandom_range(0, 3) != 0) rvalid = 1'b1;
        rready  = ($urandom_range(0, 4) != 0);
        rlast   = rvalid && rq.size() > 0 && rq[0] == 1;
        rresp   = (rvalid && r_err) ? 2'd2 : 2'd0;
        r_fired = rvalid && rready;
        if (r_fired) begin
          rq[0] = rq[0] - 1;
          inflight_m--;
          if (rq[0] == 0) void'(rq.pop_front());
        end

        arready = ($urandom_range(0, 2) != 0);
        if (arvalid && arready) begin
          obs.push_back({araddr, arlen});
          chk("credit", 64'(inflight_m + int'(arlen) + 1 <= int'(buf_free)), 64'd1);
          rq.push_back(int'(arlen) + 1);
          inflight_m += int'(arlen) + 1;
          chk("outstanding", 64'(rq.size() <= 4), 64'd1);
          chk("ar_const", {55'd0, arsize, arburst, arid}, {55'd0, 3'd4, 2'd1, 4'd0});
          prev_wait = 1'b0;
        end else begin
          prev_wait = arvalid;
          prev_ar   = {araddr, arlen};
        end
      end
    end
  end

  // Reference: walk lines in byte units, cutting at 256 bytes, line end and 4 KB pages.
  function automatic void build_model(input vec_t v);
    int          rd;
    int          li;
    int          rem;
    int          room;
    int          n;
    logic [31:0] fb;
    logic [31:0] a;
    exp_q.delete();
    rd = (v.wr == 0) ? 2 : v.wr - 1;
    fb = v.base + 32'(rd) * v.fsize;
    for (int l = 0; l < v.line_num; l++) begin
      li  = v.mode ? (v.line_num - 1 - l) : l;
      a   = fb + 32'(li) * v.stride;
      rem = v.line_bytes;
      while (rem > 0) begin
        room = 4096 - int'(a % 32'd4096);
        n = 256;
        if (rem < n) n = rem;
        if (room < n) n = room;
        exp_q.push_back({a, 8'(n / 16 - 1)});
        a   = a + 32'(n);
        rem = rem - n;
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    chk({tag, "_n"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk({tag, "_ar"}, 64'(obs[i]), 64'(exp_q[i]));
  endtask

  task automatic start_frame(input vec_t v);
    step();
    frame_mode  = v.mode;
    line_num    = 16'(v.line_num);
    line_bytes  = 16'(v.line_bytes);
    base_addr   = v.base;
    line_stride = v.stride;
    frame_size  = v.fsize;
    wr_buf_idx  = 2'(v.wr);
    buf_free    = 16'(v.free);
    enable      = 1'b1;
    obs.delete();
    fd_cnt = 0;
    ld_cnt = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fd_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step(2);
  endtask

  function automatic vec_t mk(input logic mode, input int ln, input int lb, input logic [31:0] base,
                              input logic [31:0] stride, input logic [31:0] fsize, input int wr,
                              input int free, input int en, input logic [31:0] ef, input int efl,
                              input logic [31:0] el, input int ell, input int erd, input int elines);
    vec_t v;
    v.mode = mode; v.line_num = ln; v.line_bytes = lb; v.base = base; v.stride = stride;
    v.fsize = fsize; v.wr = wr; v.free = free; v.exp_n = en; v.exp_first = ef; v.exp_flen = efl;
    v.exp_last = el; v.exp_llen = ell; v.exp_rd = erd; v.exp_lines = elines;
    return v;
  endfunction

  vec_t vt[7];
  vec_t v;
  bit   ok;
  int   n_drop;

  initial begin
    vt[0] = mk(0, 2, 1024, 32'h0,     32'h1000, 32'h0,      1, 1024, 8, 32'h0,      15, 32'h1300,   15, 0, 2);
    vt[1] = mk(1, 3, 256,  32'h0,     32'h800,  32'h0,      1, 1024, 3, 32'h1000,   15, 32'h0,      15, 0, 3);
    vt[2] = mk(0, 1, 256,  32'hFC0,   32'h0,    32'h0,      1, 1024, 2, 32'hFC0,    3,  32'h1000,   11, 0, 1);
    vt[3] = mk(0, 2, 512,  32'h0,     32'h1000, 32'h100000, 0, 1024, 4, 32'h200000, 15, 32'h201100, 15, 2, 2);
    vt[4] = mk(0, 0, 256,  32'h10,    32'h0,    32'h100,    2, 1024, 0, 32'h0,      0,  32'h0,      0,  1, 0);
    vt[5] = mk(1, 4, 0,    32'h0,     32'h100,  32'h0,      1, 1024, 0, 32'h0,      0,  32'h0,      0,  0, 0);
    vt[6] = mk(0, 2, 48,   32'h40000, 32'h30,   32'h10000,  2, 1024, 2, 32'h50000,  2,  32'h50030,  2,  1, 2);

    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; base_addr = '0; frame_size = '0;
    line_stride = '0; line_bytes = '0; line_num = '0; frame_mode = 1'b0; wr_buf_idx = '0;
    buf_free = '0; r_hold = 1'b0; r_err = 1'b0; fd_cnt = 0; ld_cnt = 0;
    step(5);
    rst_n = 1'b1;
    step(2);

    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_araddr_arlen", 64'({araddr, arlen}), 64'd0);
    chk("rst_flags", 64'({busy, line_done, frame_done, start_err, rresp_err, rd_buf_idx}), 64'd0);
    chk("rst_const", 64'({arsize, arburst, arid}), 64'({3'd4, 2'd1, 4'd0}));

    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step(3);
    chk("start_disabled_busy", 64'(busy), 64'd0);
    chk("start_disabled_err", 64'(start_err), 64'd0);

    for (int k = 0; k < 7; k++) begin
      build_model(vt[k]);
      start_frame(vt[k]);
      wait_done(3000, ok);
      chk("t_done", 64'(ok), 64'd1);
      chk("t_nar", 64'(obs.size()), 64'(vt[k].exp_n));
      if (vt[k].exp_n > 0) begin
        chk("t_first", 64'(obs[0]), 64'({vt[k].exp_first, 8'(vt[k].exp_flen)}));
        chk("t_last", 64'(obs[obs.size() - 1]), 64'({vt[k].exp_last, 8'(vt[k].exp_llen)}));
      end
      chk("t_rdidx", 64'(rd_buf_idx), 64'(vt[k].exp_rd));
      chk("t_lines", 64'(ld_cnt), 64'(vt[k].exp_lines));
      chk("t_fdone", 64'(fd_cnt), 64'd1);
      chk("t_idle", 64'(busy), 64'd0);
      compare_model("t_model");
    end

    // Credit limit: 20 free beats allow only one 16-beat burst until data returns.
    chk("no_err_yet", 64'({start_err, rresp_err}), 64'd0);
    v = mk(0, 1, 1024, 32'h2000, 32'h0, 32'h0, 1, 20, 4, 32'h2000, 15, 32'h2300, 15, 0, 1);
    build_model(v);
    r_hold = 1'b1;
    start_frame(v);
    step(40);
    chk("credit_one_ar", 64'(obs.size()), 64'd1);
    chk("credit_busy", 64'(busy), 64'd1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    chk("start_err_busy", 64'(start_err), 64'd1);
    r_hold = 1'b0;
    wait_done(3000, ok);
    chk("credit_done", 64'(ok), 64'd1);
    compare_model("credit_model");

    // Error response on returned beats.
    chk("rresp_err_clear", 64'(rresp_err), 64'd0);
    r_err = 1'b1;
    build_model(vt[1]);
    start_frame(vt[1]);
    wait_done(3000, ok);
    r_err = 1'b0;
    chk("rresp_done", 64'(ok), 64'd1);
    chk("rresp_err_set", 64'(rresp_err), 64'd1);

    // Abort mid-frame.
    v = mk(0, 4, 1024, 32'h10000, 32'h1000, 32'h0, 1, 1024, 16, 32'h10000, 15, 32'h13300, 15, 0, 4);
    build_model(v);
    start_frame(v);
    for (int i = 0; i < 500 && obs.size() < 2; i++) step();
    enable = 1'b0;
    n_drop = obs.size();
    for (int i = 0; i < 1000 && busy; i++) step();
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_ar_bound", 64'(obs.size() <= n_drop + 1), 64'd1);
    chk("abort_started", 64'(n_drop >= 2), 64'd1);
    chk("abort_no_done", 64'(fd_cnt), 64'd0);
    chk("abort_drained", 64'(rq.size()), 64'd0);
    for (int i = 0; i < obs.size(); i++) chk("abort_prefix", 64'(obs[i]), 64'(exp_q[i]));
    enable = 1'b1;
    step(2);

    // Randomized frames against the reference model.
    for (int r = 0; r < 12; r++) begin
      v.mode       = 1'($urandom_range(0, 1));
      v.line_num   = int'($urandom_range(0, 4));
      v.line_bytes = 16 * int'($urandom_range(0, 100));
      v.base       = 32'(16 * $urandom_range(0, 32'h3FFF));
      v.stride     = 32'(16 * $urandom_range(0, 32'h200));
      v.fsize      = 32'(16 * $urandom_range(0, 32'h10000));
      v.wr         = int'($urandom_range(0, 2));
      v.free       = int'($urandom_range(16, 300));
      build_model(v);
      start_frame(v);
      wait_done(6000, ok);
      chk("rand_done", 64'(ok), 64'd1);
      chk("rand_lines", 64'(ld_cnt), 64'((v.line_bytes > 0) ? v.line_num : 0));
      chk("rand_rdidx", 64'(rd_buf_idx), 64'((v.wr == 0) ? 2 : v.wr - 1));
      compare_model("rand_model");
    end

    // No rlast ever returns: outstanding limit caps at four, then async reset mid-frame.
    v = mk(0, 1, 2048, 32'h0, 32'h0, 32'h0, 1, 1024, 8, 32'h0, 15, 32'h700, 15, 0, 1);
    r_hold = 1'b1;
    start_frame(v);
    step(80);
    chk("max_outstanding", 64'(obs.size()), 64'd4);
    chk("stall_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'({busy, arvalid}), 64'd0);
    chk("async_rst_flags", 64'({start_err, rresp_err, rd_buf_idx}), 64'd0);
    step(3);
    r_hold = 1'b0;
    rst_n = 1'b1;
    step(2);
    build_model(vt[2]);
    start_frame(vt[2]);
    wait_done(3000, ok);
    chk("recover_done", 64'(ok), 64'd1);
    compare_model("recover_model");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
